// File: rtl/transmission8_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// transmission8_pkg : shared state encoding and channel count
// Rev 1.0
// ---------------------------------------------------------------------------
package transmission8_pkg;
  localparam int CHANNELS = 8;
  localparam int CH_W     = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dwell_timer : 8-bit dwell counter, terminal count at DWELL-1
// Rev 1.0
// ---------------------------------------------------------------------------
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam logic [7:0] TC_VAL = 8'(DWELL - 1);

  logic [7:0] cnt_q;

  assign tc_o = (cnt_q == TC_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'h00;
    end else if (clr_i) begin
      cnt_q <= 8'h00;
    end else if (en_i) begin
      cnt_q <= tc_o ? 8'h00 : cnt_q + 8'h01;
    end
  end
endmodule
`default_nettype wire

// File: rtl/transmission8_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// transmission8_scan : walks an 8-way channel select across a captured frame
// Rev 1.0
// ---------------------------------------------------------------------------
module transmission8_scan
  import transmission8_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iHold,
  input  logic       iAbort,
  output logic [7:0] oData,
  output logic       oA,
  output logic       oB,
  output logic       oC,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oFrames
);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  state_e          state_q;
  logic [CH_W-1:0] chan_q;
  logic [7:0]      data_q;
  logic [7:0]      frames_q;
  logic            busy_q;
  logic            done_q;
  logic            dwell_tc;

  // Counter is held at zero outside SCAN so every scan starts on a fresh dwell.
  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i ((state_q != SCAN) || iAbort),
    .en_i  ((state_q == SCAN) && !iHold),
    .tc_o  (dwell_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      chan_q   <= '0;
      data_q   <= 8'h00;
      frames_q <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iStart && !iAbort) begin
            data_q  <= iData;
            chan_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (iAbort) begin
            chan_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!iHold && dwell_tc) begin
            if (chan_q == LAST_CH) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              chan_q <= chan_q + 1'b1;
            end
          end
        end
        DONE: begin
          // An abort landing on the DONE cycle discards the frame credit.
          if (!iAbort) begin
            frames_q <= frames_q + 8'h01;
          end
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          chan_q  <= '0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          chan_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oData   = data_q;
  assign oA      = chan_q[2];
  assign oB      = chan_q[1];
  assign oC      = chan_q[0];
  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oFrames = frames_q;
endmodule
`default_nettype wire

// File: tb/tb_transmission8_scan.sv
`default_nettype none
// Bench: two instances (DWELL=4 and DWELL=1) driven in parallel and checked
// each cycle against a progress-count model, plus directed literal checks.
module tb_transmission8_scan;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iStart = 1'b0, iHold = 1'b0, iAbort = 1'b0;
  logic [7:0] iData = 8'h00;

  logic [7:0] d4, d1, f4, f1;
  logic       a4, b4, c4, bz4, dn4;
  logic       a1, b1, c1, bz1, dn1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  transmission8_scan #(.DWELL(4)) u4 (
    .clk(clk), .rst_n(rst_n), .iStart(iStart), .iData(iData), .iHold(iHold),
    .iAbort(iAbort), .oData(d4), .oA(a4), .oB(b4), .oC(c4), .oBusy(bz4),
    .oDone(dn4), .oFrames(f4));

  transmission8_scan #(.DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .iStart(iStart), .iData(iData), .iHold(iHold),
    .iAbort(iAbort), .oData(d1), .oA(a1), .oB(b1), .oC(c1), .oBusy(bz1),
    .oDone(dn1), .oFrames(f1));

  // Model: p counts un-held SCAN cycles since the start; channel = p / DWELL.
  typedef struct {
    bit       busy;
    bit       done;
    bit [7:0] data;
    bit [7:0] frames;
    int       p;
  } model_t;

  localparam model_t RST = '{busy: 1'b0, done: 1'b0, data: 8'h00, frames: 8'h00, p: 0};

  model_t m4 = RST;
  model_t m1 = RST;

  function automatic model_t step(model_t s, int dw, bit st, bit ab, bit hd, bit [7:0] d);
    model_t n = s;
    if (!s.busy) begin
      if (st && !ab) begin
        n.busy = 1'b1;
        n.data = d;
        n.p    = 0;
      end
    end else if (s.done) begin
      n.done = 1'b0;
      n.busy = 1'b0;
      n.p    = 0;
      if (!ab) n.frames = s.frames + 8'd1;
    end else if (ab) begin
      n.busy = 1'b0;
      n.p    = 0;
    end else if (!hd) begin
      n.p = s.p + 1;
      if (n.p == 8 * dw) n.done = 1'b1;
    end
    return n;
  endfunction

  function automatic bit [2:0] exp_sel(model_t s, int dw);
    if (s.done) return 3'd7;
    if (!s.busy) return 3'd0;
    return 3'(s.p / dw);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= RST;
      m1 <= RST;
    end else begin
      m4 <= step(m4, 4, iStart, iAbort, iHold, iData);
      m1 <= step(m1, 1, iStart, iAbort, iHold, iData);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(string tag, model_t m, int dw, logic [7:0] d, logic [2:0] sel,
                     logic bz, logic dn, logic [7:0] fr);
    chk({tag, ".oData"},   32'(d),   32'(m.data));
    chk({tag, ".sel"},     32'(sel), 32'(exp_sel(m, dw)));
    chk({tag, ".oBusy"},   32'(bz),  32'(m.busy));
    chk({tag, ".oDone"},   32'(dn),  32'(m.done));
    chk({tag, ".oFrames"}, 32'(fr),  32'(m.frames));
  endtask

  always @(negedge clk) begin
    cmp("u4", m4, 4, d4, {a4, b4, c4}, bz4, dn4, f4);
    cmp("u1", m1, 1, d1, {a1, b1, c1}, bz1, dn1, f1);
  end

  // Pulse iStart for one edge; returns count of edges until u4 oDone (0 on timeout).
  task automatic run_u4(input logic [7:0] data, input int hold_from, input int hold_to,
                        input int abort_at, output int n_done);
    int n = 0;
    n_done = 0;
    @(negedge clk);
    iStart = 1'b1;
    iData  = data;
    @(negedge clk);
    iStart = 1'b0;
    while (n < 60) begin
      if (dn4) begin
        n_done = n;
        break;
      end
      if (n == abort_at) break;
      iHold = (n >= hold_from && n < hold_to);
      @(negedge clk);
      n++;
      if (n == 4)  chk("nominal.sel_ch1", 32'({a4, b4, c4}), 32'd1);
      if (n == 10) begin
        iStart = 1'b1;
        iData  = 8'h55;
      end
      if (n == 11) begin
        iStart = 1'b0;
        iData  = 8'h00;
      end
    end
    iHold = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset.oData",   32'(d4),  32'h00);
    chk("reset.oBusy",   32'(bz4), 32'h0);
    chk("reset.oFrames", 32'(f4),  32'h00);
    rst_n = 1'b1;

    // Nominal scan
    run_u4(8'hAA, -1, -1, -1, n);
    chk("nominal.done_cycle", 32'(n), 32'd32);
    chk("nominal.sel_done",   32'({a4, b4, c4}), 32'd7);
    chk("nominal.busy_ignore.oData", 32'(d4), 32'hAA);
    @(negedge clk);
    chk("nominal.oFrames", 32'(f4), 32'd1);
    chk("nominal.oBusy",   32'(bz4), 32'd0);
    chk("nominal.sel_idle", 32'({a4, b4, c4}), 32'd0);

    // Hold for 5 edges during channel 3
    run_u4(8'h3C, 13, 18, -1, n);
    chk("hold.done_cycle", 32'(n), 32'd37);
    @(negedge clk);
    chk("hold.oFrames", 32'(f4), 32'd2);

    // Abort during channel 5
    run_u4(8'hAA, -1, -1, 21, n);
    chk("abort.sel_ch5", 32'({a4, b4, c4}), 32'd5);
    iAbort = 1'b1;
    @(negedge clk);
    iAbort = 1'b0;
    chk("abort.oBusy", 32'(bz4), 32'd0);
    chk("abort.sel",   32'({a4, b4, c4}), 32'd0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (dn4) n++;
    end
    chk("abort.no_done", 32'(n), 32'd0);
    chk("abort.oFrames", 32'(f4), 32'd2);
    iStart = 1'b1;
    iAbort = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    iAbort = 1'b0;
    chk("start_abort.oBusy", 32'(bz4), 32'd0);

    // Busy-ignore then asynchronous reset during channel 6
    run_u4(8'hAA, -1, -1, 25, n);
    chk("busy.oData", 32'(d4), 32'hAA);
    chk("busy.sel_ch6", 32'({a4, b4, c4}), 32'd6);
    #3 rst_n = 1'b0;
    #1;
    chk("areset.oData",   32'(d4), 32'h00);
    chk("areset.sel",     32'({a4, b4, c4}), 32'd0);
    chk("areset.oBusy",   32'(bz4), 32'd0);
    chk("areset.oFrames", 32'(f4), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    iStart = 1'b1;
    iData  = 8'hC3;

    // 256 back-to-back scans at DWELL=1: 10 edges per scan with iStart held
    repeat (9) @(negedge clk);
    chk("wrap.first_done", 32'(dn1), 32'd1);
    repeat (2541) @(negedge clk);
    chk("wrap.frames_255", 32'(f1), 32'd255);
    repeat (10) @(negedge clk);
    chk("wrap.frames_0", 32'(f1), 32'd0);
    iStart = 1'b0;

    // Randomized traffic
    repeat (3000) begin
      @(negedge clk);
      iStart = ($urandom_range(0, 3) == 0);
      iHold  = ($urandom_range(0, 3) == 0);
      iAbort = ($urandom_range(0, 63) == 0);
      iData  = 8'($urandom);
    end
    iStart = 1'b0;
    iHold  = 1'b0;
    iAbort = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
